// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and width helpers for the fetch queue unit.
package fetch_queue_unit_pkg;

    localparam int unsigned FQ_D_WIDTH = 32;
    localparam int unsigned FQ_A_WIDTH = 32;

    localparam logic [FQ_D_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_A_WIDTH-1:0] pc;
        logic [FQ_D_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch queue unit.
interface fetch_queue_unit_if #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned A_WIDTH = 32
);
    logic               pc_src_e;
    logic [A_WIDTH-1:0] pc_target_e;
    logic               imem_req;
    logic [A_WIDTH-1:0] imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [D_WIDTH-1:0] imem_rdata;
    logic               instr_valid_d;
    logic               instr_ready_d;
    logic [D_WIDTH-1:0] instr_d;
    logic [A_WIDTH-1:0] pc_d;
    logic [A_WIDTH-1:0] pc_4_d;

    modport master (
        input  pc_src_e, pc_target_e, imem_gnt, imem_rvalid, imem_rdata, instr_ready_d,
        output imem_req, imem_addr, instr_valid_d, instr_d, pc_d, pc_4_d
    );

    modport slave (
        output pc_src_e, pc_target_e, imem_gnt, imem_rvalid, imem_rdata, instr_ready_d,
        input  imem_req, imem_addr, instr_valid_d, instr_d, pc_d, pc_4_d
    );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and single-cycle flush.
module fetch_queue_unit_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head_c,
    output logic [CW-1:0] count,
    output logic          empty_c
);
    localparam int unsigned PW = ptr_width(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointer/count update; flush wins over everything else.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty_c = (count_q == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: in-order instruction memory requests, response queue, redirect with squash.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned        D_WIDTH   = FQ_D_WIDTH,
    parameter int unsigned        A_WIDTH   = FQ_A_WIDTH,
    parameter logic [A_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned        Q_DEPTH   = 4,
    parameter int unsigned        MAX_OUTST = 2
) (
    input logic               clk,
    input logic               rst_n,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned OW = cnt_width(MAX_OUTST);
    localparam int unsigned CW = cnt_width(Q_DEPTH);

    logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [A_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]      outst_q, outst_d;
    logic [OW-1:0]      drop_q, drop_d;
    logic               en_q, en_d;

    logic [A_WIDTH-1:0] target_c;
    logic [CW-1:0]      q_count;
    int unsigned        used_c;
    logic               imem_req_c, accept_c, rsp_c, push_c, pop_c, valid_c;
    fetch_entry_t       push_entry_c, head_c;
    logic               empty_c;

    // Issue/response bookkeeping; queue space is reserved when a request is accepted.
    always_comb begin
        target_c   = bus.pc_target_e & ~A_WIDTH'(3);
        used_c     = 32'(q_count) + 32'(outst_q);
        imem_req_c = en_q && !bus.pc_src_e && (32'(outst_q) < MAX_OUTST) && (used_c < Q_DEPTH);
        accept_c   = imem_req_c && bus.imem_gnt;
        rsp_c      = bus.imem_rvalid && (outst_q != '0);
        push_c     = rsp_c && (drop_q == '0) && !bus.pc_src_e;

        en_d       = 1'b1;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + OW'(accept_c) - OW'(rsp_c);

        if (bus.pc_src_e) begin
            fetch_pc_d = target_c;
            resp_pc_d  = target_c;
            // Everything still in flight after this cycle's response belongs to the old path.
            drop_d     = outst_q - OW'(rsp_c);
        end else begin
            if (accept_c) fetch_pc_d = fetch_pc_q + A_WIDTH'(4);
            if (push_c)   resp_pc_d  = resp_pc_q + A_WIDTH'(4);
            if (rsp_c && (drop_q != '0)) drop_d = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            en_q       <= en_d;
        end
    end

    assign push_entry_c.pc    = FQ_A_WIDTH'(resp_pc_q);
    assign push_entry_c.instr = FQ_D_WIDTH'(bus.imem_rdata);
    assign valid_c            = !empty_c;
    assign pop_c              = valid_c && bus.instr_ready_d;

    fetch_queue_unit_fifo #(
        .DEPTH (Q_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .pop       (pop_c),
        .flush     (bus.pc_src_e),
        .push_data (push_entry_c),
        .head_c    (head_c),
        .count     (q_count),
        .empty_c   (empty_c)
    );

    // Decode-side outputs are forced to NOP/0 while the queue is empty.
    assign bus.imem_req      = imem_req_c;
    assign bus.imem_addr     = fetch_pc_q;
    assign bus.instr_valid_d = valid_c;
    assign bus.instr_d       = valid_c ? D_WIDTH'(head_c.instr) : D_WIDTH'(NOP_INSTR);
    assign bus.pc_d          = valid_c ? A_WIDTH'(head_c.pc) : '0;
    assign bus.pc_4_d        = valid_c ? A_WIDTH'(head_c.pc) + A_WIDTH'(4) : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order fixed-latency memory model.
module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;

    localparam logic [31:0] KEY = 32'h5A5A_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.D_WIDTH(32), .A_WIDTH(32)) bus ();

    fetch_queue_unit #(
        .D_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'h0), .Q_DEPTH(4), .MAX_OUTST(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          outst_tb = 0;
    int          max_outst = 0;
    int          pops = 0;
    int          first_valid_cyc = -1;
    bit          stale_rv = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] rsp_data_q[$];
    int          rsp_due_q[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: present memory response, record accepts, check popped entries, advance.
    task automatic tick();
        bit          acc, rsp;
        logic [31:0] p4, ins;
        if (stale_rv) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end else if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = rsp_data_q[0];
            void'(rsp_due_q.pop_front());
            void'(rsp_data_q.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        #1;
        acc = bus.imem_req && bus.imem_gnt && rst_n;
        rsp = bus.imem_rvalid && (outst_tb > 0) && rst_n;
        if (outst_tb >= 2) chk("req_at_max_outst", 64'(bus.imem_req), 64'h0);
        if (acc) begin
            rsp_due_q.push_back(cyc + lat);
            rsp_data_q.push_back(bus.imem_addr ^ KEY);
            acc_log.push_back(bus.imem_addr);
            acc_cyc.push_back(cyc);
        end
        outst_tb = outst_tb + int'(acc) - int'(rsp);
        if (outst_tb > max_outst) max_outst = outst_tb;
        if (bus.instr_valid_d && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.instr_valid_d && bus.instr_ready_d) begin
            p4  = exp_pc + 32'd4;
            ins = exp_pc ^ KEY;
            chk("pc_d", 64'(bus.pc_d), 64'(exp_pc));
            chk("instr_d", 64'(bus.instr_d), 64'(ins));
            chk("pc_4_d", 64'(bus.pc_4_d), 64'(p4));
            exp_pc = p4;
            pops++;
        end
        if (bus.pc_src_e) exp_pc = {bus.pc_target_e[31:2], 2'b00};
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   64'(bus.imem_req), 64'h0);
        chk({tag, "_valid"}, 64'(bus.instr_valid_d), 64'h0);
        chk({tag, "_instr"}, 64'(bus.instr_d), 64'(NOP));
        chk({tag, "_pc"},    64'(bus.pc_d), 64'h0);
        chk({tag, "_pc4"},   64'(bus.pc_4_d), 64'h0);
    endtask

    task automatic run_until_outst2(input string tag);
        for (int b = 0; b < 20 && outst_tb != 2; b++) tick();
        chk(tag, 64'(outst_tb), 64'd2);
    endtask

    task automatic wait_req(input string tag);
        #1;
        for (int b = 0; b < 10 && !bus.imem_req; b++) begin
            tick();
            #1;
        end
        chk(tag, 64'(bus.imem_req), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int pops0;
        rst_n             = 1'b0;
        bus.pc_src_e      = 1'b0;
        bus.pc_target_e   = 32'h0;
        bus.imem_gnt      = 1'b1;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.instr_ready_d = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single-cycle memory, streaming from RESET_PC
        lat = 1;
        acc_log.delete(); acc_cyc.delete(); first_valid_cyc = -1;
        repeat (12) tick();
        chk("t1_addr0", 64'(acc_log[0]), 64'h0);
        chk("t1_addr1", 64'(acc_log[1]), 64'h4);
        chk("t1_addr2", 64'(acc_log[2]), 64'h8);
        chk("t1_addr3", 64'(acc_log[3]), 64'hC);
        chk("t1_latency", 64'(first_valid_cyc - acc_cyc[0]), 64'd2);
        chk("t1_streaming", 64'(pops >= 8), 64'h1);

        // 2: three-cycle memory, outstanding limit
        lat = 3; max_outst = 0;
        pops0 = pops;
        repeat (20) tick();
        chk("t2_max_outst", 64'(max_outst), 64'd2);
        chk("t2_progress", 64'(pops > pops0), 64'h1);

        // 3: decode stall fills the queue, then drains without loss
        lat = 1;
        bus.instr_ready_d = 1'b0;
        repeat (10) tick();
        #1;
        chk("t3_valid", 64'(bus.instr_valid_d), 64'h1);
        chk("t3_req_full", 64'(bus.imem_req), 64'h0);
        chk("t3_head_pc", 64'(bus.pc_d), 64'(exp_pc));
        chk("t3_outst", 64'(outst_tb), 64'd0);
        bus.instr_ready_d = 1'b1;
        pops0 = pops;
        repeat (12) tick();
        chk("t3_resume", 64'(pops - pops0 >= 8), 64'h1);

        // 4: redirect with two requests in flight
        lat = 3;
        run_until_outst2("t4_reach_outst2");
        bus.pc_src_e = 1'b1; bus.pc_target_e = 32'h0000_0100;
        #1;
        chk("t4_req_redirect", 64'(bus.imem_req), 64'h0);
        tick();
        bus.pc_src_e = 1'b0;
        acc_log.delete();
        for (int b = 0; b < 20 && acc_log.size() == 0; b++) tick();
        chk("t4_first_addr", 64'(acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF), 64'h100);
        for (int b = 0; b < 20 && !bus.instr_valid_d; b++) tick();
        chk("t4_first_pc", 64'(bus.pc_d), 64'h100);
        repeat (6) tick();

        // 5: unaligned target, back-to-back redirects and PC wrap
        lat = 1;
        bus.pc_src_e = 1'b1; bus.pc_target_e = 32'h0000_0103;
        tick();
        bus.pc_src_e = 1'b0;
        wait_req("t5_req_a");
        chk("t5_aligned_addr", 64'(bus.imem_addr), 64'h100);
        repeat (3) tick();
        bus.pc_src_e = 1'b1; bus.pc_target_e = 32'h0000_0200;
        tick();
        bus.pc_target_e = 32'hFFFF_FFFC;
        tick();
        bus.pc_src_e = 1'b0;
        wait_req("t5_req_b");
        chk("t5_last_wins", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        tick();
        wait_req("t5_req_c");
        chk("t5_wrap", 64'(bus.imem_addr), 64'h0);
        repeat (8) tick();

        // 6: reset mid-stream, stale response afterwards
        lat = 3;
        run_until_outst2("t6_reach_outst2");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        rsp_due_q.delete(); rsp_data_q.delete(); outst_tb = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; bus.imem_gnt = 1'b0; stale_rv = 1'b1;
        repeat (3) tick();
        chk("t6_stale_ignored", 64'(bus.instr_valid_d), 64'h0);
        stale_rv = 1'b0; bus.imem_gnt = 1'b1;
        exp_pc = 32'h0; acc_log.delete();
        for (int b = 0; b < 10 && acc_log.size() == 0; b++) tick();
        chk("t6_restart_addr", 64'(acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF), 64'h0);
        for (int b = 0; b < 20 && !bus.instr_valid_d; b++) tick();
        chk("t6_first_pc", 64'(bus.pc_d), 64'h0);
        chk("t6_first_instr", 64'(bus.instr_d), 64'(KEY));
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
